// File: rtl/eth_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_stream_pkg
// Brief    : Shared stream types and helpers for the eth_clk datapath.
// Revision : 1.0 - initial release
// ============================================================================
package eth_stream_pkg;

  localparam int c_word_bytes    = 4;
  localparam int c_payload_words = 128;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } framer_state_t;

  // Reverse byte order: byte 0 of the input lands in the top byte of the result.
  function automatic logic [c_word_bytes*8-1:0] byte_swap(input logic [c_word_bytes*8-1:0] d);
    logic [c_word_bytes*8-1:0] r;
    for (int i = 0; i < c_word_bytes; i++) begin
      r[i*8 +: 8] = d[(c_word_bytes-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/framer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : framer_fifo
// Brief    : Single-clock first-word-fall-through FIFO with registered level.
// Revision : 1.0 - initial release
// ============================================================================
module framer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_level;

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

endmodule
`default_nettype wire

// File: rtl/mic_stream_framer.sv
`default_nettype none
// ============================================================================
// Module   : mic_stream_framer
// Brief    : Buffers free-running mic samples and emits fixed-length AXIS frames.
// Revision : 1.0 - initial release
// ============================================================================
module mic_stream_framer
  import eth_stream_pkg::*;
#(
  parameter int WORD_BYTES    = c_word_bytes,
  parameter int PAYLOAD_WORDS = c_payload_words,
  parameter int FIFO_DEPTH    = 256,
  parameter int SWAP_ENDIAN   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WORD_BYTES*8-1:0]       s_data,
  input  logic                          s_valid,
  output logic [WORD_BYTES*8-1:0]       m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count
);

  localparam int                c_lw        = $clog2(FIFO_DEPTH) + 1;
  localparam int                c_bw        = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [c_lw-1:0]   c_depth     = c_lw'(FIFO_DEPTH);
  localparam logic [c_lw-1:0]   c_payload   = c_lw'(PAYLOAD_WORDS);
  localparam logic [c_bw-1:0]   c_last_beat = c_bw'(PAYLOAD_WORDS - 1);

  framer_state_t              r_state;
  framer_state_t              w_state_next;
  logic [c_bw-1:0]            r_beat_cnt;
  logic [15:0]                r_ovf_cnt;
  logic [c_lw-1:0]            w_level;
  logic [WORD_BYTES*8-1:0]    w_head;
  logic [WORD_BYTES*8-1:0]    w_head_out;
  logic                       w_handshake;
  logic                       w_wr_accept;
  logic                       w_drop;

  assign w_handshake = m_axis_tvalid & m_axis_tready;
  // A full FIFO still takes a sample when a slot is freed on the same edge.
  assign w_wr_accept = s_valid & ((w_level < c_depth) | w_handshake);
  assign w_drop      = s_valid & ~w_wr_accept;

  framer_fifo #(
    .WIDTH (WORD_BYTES*8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_accept),
    .wr_data (s_data),
    .rd_en   (w_handshake),
    .rd_data (w_head),
    .level   (w_level)
  );

  generate
    if (SWAP_ENDIAN != 0 && WORD_BYTES == c_word_bytes) begin : g_swap_pkg
      assign w_head_out = byte_swap(w_head);
    end else if (SWAP_ENDIAN != 0) begin : g_swap_loop
      for (genvar b = 0; b < WORD_BYTES; b++) begin : g_byte
        assign w_head_out[b*8 +: 8] = w_head[(WORD_BYTES-1-b)*8 +: 8];
      end
    end else begin : g_swap_none
      assign w_head_out = w_head;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A frame only starts once it is fully buffered, so it can never starve mid-frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_level >= c_payload) w_state_next = STREAM;
      STREAM:  if (w_handshake && (r_beat_cnt == c_last_beat)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    if (r_state == STREAM) begin
      m_axis_tvalid = 1'b1;
      m_axis_tlast  = (r_beat_cnt == c_last_beat);
      m_axis_tdata  = w_head_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_handshake) begin
      r_beat_cnt <= (r_beat_cnt == c_last_beat) ? '0 : r_beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign fifo_level     = w_level;
  assign overflow_count = r_ovf_cnt;

endmodule
`default_nettype wire
